// File: rtl/heroe_pkg.sv
// Shared definitions for the HEROE runner game: game state encodings,
// obstacle geometry and the obstacle-type mapping helper.
package heroe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } game_state_t;

    localparam int OBS_TYPES = 10;
    localparam int OBS_W     = 7;
    localparam int SCORE_W   = 16;

    // Fold a 4-bit random nibble onto the 0..OBS_TYPES-1 ROM index range.
    function automatic logic [3:0] map_obs_type(input logic [3:0] nibble);
        logic [3:0] result;
        if (nibble < 4'(OBS_TYPES)) begin
            result = nibble;
        end else begin
            result = nibble - 4'(OBS_TYPES);
        end
        return result;
    endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances only when enabled and
// presents the new low nibble, folded to 0..9, as the obstacle type.
module obstacle_lfsr
    import heroe_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] tipo_obs
);

    logic [7:0] lfsr_r;
    logic [7:0] lfsr_nxt_s;
    logic [3:0] tipo_r;

    // Next LFSR value: shift left, feedback from taps 8,6,5,4.
    always_comb begin
        lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end

    // LFSR and type register; the type is taken from the post-shift value.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED;
            tipo_r <= 4'd0;
        end else if (en) begin
            lfsr_r <= lfsr_nxt_s;
            tipo_r <= map_obs_type(lfsr_nxt_s[3:0]);
        end else begin
            lfsr_r <= lfsr_r;
            tipo_r <= tipo_r;
        end
    end

    assign tipo_obs = tipo_r;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle sequencer for the HEROE runner: game FSM, scroll tick, column
// buffer, gap insertion and score counting.
// Optional build macro OBSTACLE_SPEEDUP_EN shortens the scroll period every
// 8 points; without it the period is the constant TICK_DIV.
module obstacle_scheduler
    import heroe_pkg::*;
#(
    parameter int         TICK_DIV = 4,
    parameter int         N_COLS   = 8,
    parameter int         GAP_MIN  = 2,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      collision,
    output logic [3:0]                tipo_obs,
    input  logic [6:0]                obstaculo,
    output logic [N_COLS*7-1:0]       col_out,
    output logic                      step,
    output logic [15:0]               score,
    output logic [1:0]                state
);

    localparam int TW    = $clog2(TICK_DIV + 1);
    localparam int GAP_W = (GAP_MIN < 1) ? 1 : $clog2(GAP_MIN + 1);
    localparam int BUF_W = N_COLS * OBS_W;

    localparam logic [TW-1:0]    TICK_DIV_C = TW'(TICK_DIV);
    localparam logic [GAP_W-1:0] GAP_MIN_C  = GAP_W'(GAP_MIN);

    game_state_t         state_r, state_nxt_s;
    logic [BUF_W-1:0]    col_r;
    logic [SCORE_W-1:0]  score_r, score_nxt_s;
    logic [TW-1:0]       tick_r;
    logic [TW-1:0]       period_s;
    logic [GAP_W-1:0]    gap_r;
    logic                step_r;
    logic                restart_s;
    logic                run_tick_s;
    logic                do_step_s;
    logic                score_inc_s;
    logic [OBS_W-1:0]    ins_col_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control; collision outranks pause, pause outranks a step.
    always_comb begin
        state_nxt_s = state_r;
        restart_s   = 1'b0;
        run_tick_s  = 1'b0;
        do_step_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    restart_s   = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (collision) begin
                    state_nxt_s = ST_OVER;
                end else if (pause) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                    run_tick_s  = 1'b1;
                    do_step_s   = (tick_r == (period_s - TW'(1)));
                end
            end
            ST_PAUSE: begin
                if (collision) begin
                    state_nxt_s = ST_OVER;
                end else if (!pause) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Column to insert and score increment decision for the current step.
    always_comb begin
        score_nxt_s = score_r + 16'd1;
        if (gap_r == GAP_MIN_C) begin
            ins_col_s = obstaculo;
        end else begin
            ins_col_s = {OBS_W{1'b0}};
        end
        score_inc_s = do_step_s && (col_r[OBS_W-1:0] != {OBS_W{1'b0}})
                      && (score_r != 16'hFFFF);
    end

    // Buffer, score, tick, gap counter and step pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r   <= {BUF_W{1'b0}};
            score_r <= 16'd0;
            tick_r  <= {TW{1'b0}};
            gap_r   <= {GAP_W{1'b0}};
            step_r  <= 1'b0;
        end else if (restart_s) begin
            col_r   <= {BUF_W{1'b0}};
            score_r <= 16'd0;
            tick_r  <= {TW{1'b0}};
            gap_r   <= {GAP_W{1'b0}};
            step_r  <= 1'b0;
        end else if (do_step_s) begin
            col_r   <= {ins_col_s, col_r[BUF_W-1:OBS_W]};
            score_r <= score_inc_s ? score_nxt_s : score_r;
            tick_r  <= {TW{1'b0}};
            gap_r   <= (gap_r == GAP_MIN_C) ? {GAP_W{1'b0}} : gap_r + GAP_W'(1);
            step_r  <= 1'b1;
        end else if (run_tick_s) begin
            tick_r  <= tick_r + TW'(1);
            step_r  <= 1'b0;
        end else begin
            step_r  <= 1'b0;
        end
    end

`ifdef OBSTACLE_SPEEDUP_EN
    localparam int DEC_I   = TICK_DIV / 8;
    localparam int FLOOR_I = (TICK_DIV / 4 < 1) ? 1 : TICK_DIV / 4;
    localparam logic [TW-1:0] DEC_C   = TW'(DEC_I);
    localparam logic [TW-1:0] FLOOR_C = TW'(FLOOR_I);

    logic [TW-1:0] period_r;

    // Shorten the scroll period each time the score reaches a multiple of 8.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r <= TICK_DIV_C;
        end else if (restart_s) begin
            period_r <= TICK_DIV_C;
        end else if (score_inc_s && (score_nxt_s[2:0] == 3'd0)) begin
            if (period_r >= (FLOOR_C + DEC_C)) begin
                period_r <= period_r - DEC_C;
            end else begin
                period_r <= FLOOR_C;
            end
        end else begin
            period_r <= period_r;
        end
    end

    assign period_s = period_r;
`else
    assign period_s = TICK_DIV_C;
`endif

    obstacle_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (do_step_s),
        .tipo_obs (tipo_obs)
    );

    assign col_out = col_r;
    assign step    = step_r;
    assign score   = score_r;
    assign state   = state_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed self-checking bench for obstacle_scheduler (TICK_DIV=4, N_COLS=8,
// GAP_MIN=2) with a small obstacle ROM model.
module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause;
    logic        collision;
    logic [3:0]  tipo_obs;
    logic [6:0]  obstaculo;
    logic [55:0] col_out;
    logic        step;
    logic [15:0] score;
    logic [1:0]  state;
    logic        use_fixed;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] rom_model(input logic [3:0] t);
        case (t)
            4'd0: rom_model = 7'h41;
            4'd1: rom_model = 7'h22;
            4'd2: rom_model = 7'h14;
            4'd3: rom_model = 7'h08;
            4'd4: rom_model = 7'h3E;
            4'd5: rom_model = 7'h1C;
            4'd6: rom_model = 7'h63;
            4'd7: rom_model = 7'h7F;
            4'd8: rom_model = 7'h55;
            4'd9: rom_model = 7'h2A;
            default: rom_model = 7'h00;
        endcase
    endfunction

    assign obstaculo = use_fixed ? 7'h63 : rom_model(tipo_obs);

    obstacle_scheduler #(
        .TICK_DIV (4),
        .N_COLS   (8),
        .GAP_MIN  (2),
        .SEED     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .collision (collision),
        .tipo_obs  (tipo_obs),
        .obstaculo (obstaculo),
        .col_out   (col_out),
        .step      (step),
        .score     (score),
        .state     (state)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next step pulse.
    task automatic wait_step();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            seen = step;
        end
        if (!seen) check_val("step_timeout", 64'd0, 64'd1);
    endtask

    // Expected buffer after step k with a fixed 7'h63 ROM: obstacle inserted on every third step.
    function automatic logic [55:0] exp_cols(input int k);
        logic [55:0] v;
        int j;
        v = 56'd0;
        for (int i = 0; i < 8; i++) begin
            j = k - (7 - i);
            if (j >= 1 && (j % 3) == 0) v[i*7 +: 7] = 7'h63;
        end
        return v;
    endfunction

`ifdef OBSTACLE_SPEEDUP_EN
    logic        f_rst, f_start;
    logic [3:0]  f_tipo;
    logic [55:0] f_col;
    logic        f_step;
    logic [15:0] f_score;
    logic [1:0]  f_state;

    obstacle_scheduler #(
        .TICK_DIV (32),
        .N_COLS   (8),
        .GAP_MIN  (2),
        .SEED     (8'hA5)
    ) dut_fast (
        .clk       (clk),
        .rst       (f_rst),
        .start     (f_start),
        .pause     (1'b0),
        .collision (1'b0),
        .tipo_obs  (f_tipo),
        .obstaculo (7'h63),
        .col_out   (f_col),
        .step      (f_step),
        .score     (f_score),
        .state     (f_state)
    );
`endif

    initial begin
        logic [55:0] snap_col;
        logic [15:0] snap_score;
        logic [3:0]  t;
        int          exp_sc;

        rst = 1'b1; start = 1'b0; pause = 1'b0; collision = 1'b0; use_fixed = 1'b1;
        cyc(); cyc();
        check_val("rst_state", 64'(state), 64'd0);
        check_val("rst_col",   64'(col_out), 64'd0);
        check_val("rst_score", 64'(score), 64'd0);
        check_val("rst_tipo",  64'(tipo_obs), 64'd0);
        check_val("rst_step",  64'(step), 64'd0);

        // Start and fill / score
        rst = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("start_state", 64'(state), 64'd1);
        for (int k = 1; k <= 14; k++) begin
            for (int c = 0; c < 3; c++) begin
                cyc();
                check_val("step_low", 64'(step), 64'd0);
            end
            cyc();
            check_val("step_high", 64'(step), 64'd1);
            check_val("fill_cols", 64'(col_out), 64'(exp_cols(k)));
            exp_sc = (k >= 11) ? (k - 8) / 3 : 0;
            check_val("fill_score", 64'(score), 64'(exp_sc));
        end

        // Type range with the real ROM
        use_fixed = 1'b0;
        for (int s = 0; s < 200; s++) begin
            wait_step();
            t = tipo_obs;
            check_val("tipo_range", 64'(t <= 4'd9), 64'd1);
            for (int c = 0; c < 3; c++) begin
                cyc();
                check_val("tipo_hold", 64'(tipo_obs), 64'(t));
            end
        end

        // Pause right after a step
        wait_step();
        snap_col = col_out;
        snap_score = score;
        pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            check_val("pause_step", 64'(step), 64'd0);
        end
        check_val("pause_state", 64'(state), 64'd2);
        check_val("pause_col",   64'(col_out), 64'(snap_col));
        check_val("pause_score", 64'(score), 64'(snap_score));
        pause = 1'b0;
        cyc();
        check_val("resume_state", 64'(state), 64'd1);

        // Collision on a step cycle
        wait_step();
        cyc(); cyc(); cyc();
        snap_col = col_out;
        snap_score = score;
        collision = 1'b1;
        cyc();
        check_val("coll_state", 64'(state), 64'd3);
        check_val("coll_step",  64'(step), 64'd0);
        check_val("coll_col",   64'(col_out), 64'(snap_col));
        check_val("coll_score", 64'(score), 64'(snap_score));
        cyc(); cyc();
        collision = 1'b0;
        cyc();
        check_val("over_state", 64'(state), 64'd3);
        check_val("over_col",   64'(col_out), 64'(snap_col));
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("restart_state", 64'(state), 64'd1);
        check_val("restart_score", 64'(score), 64'd0);
        check_val("restart_col",   64'(col_out), 64'd0);

        // Reset mid-game
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_val("midrst_state", 64'(state), 64'd0);
        check_val("midrst_tipo",  64'(tipo_obs), 64'd0);

`ifdef OBSTACLE_SPEEDUP_EN
        begin
            int  prev_c, prev_sc;
            bit  done8, done48;
            f_rst = 1'b1; f_start = 1'b0;
            cyc(); cyc();
            f_rst = 1'b0;
            f_start = 1'b1;
            cyc();
            f_start = 1'b0;
            prev_c = 0; prev_sc = 0; done8 = 1'b0; done48 = 1'b0;
            for (int c = 1; c < 20000 && !done48; c++) begin
                cyc();
                if (f_step) begin
                    if (prev_sc == 8 && !done8) begin
                        check_val("speed_28", 64'(c - prev_c), 64'd28);
                        done8 = 1'b1;
                    end
                    if (prev_sc == 48) begin
                        check_val("speed_floor", 64'(c - prev_c), 64'd8);
                        done48 = 1'b1;
                    end
                    prev_c = c;
                    prev_sc = int'(f_score);
                end
            end
            if (!done48) check_val("speed_timeout", 64'd0, 64'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Sequences obstacle generation for the HEROE runner game.
- Every scroll step it picks an obstacle type for the obstacle pattern ROM and latches the 7-bit pattern the ROM returns.
- It scrolls a column buffer toward the hero column, counts passed obstacles and stops on collision.
- Sits between the game top level (start/pause/collision) and the display driver (col_out).

Parameters:
TICK_DIV, 4, clock cycles per scroll step (>=4)
N_COLS, 8, display columns held in the buffer (>=2)
GAP_MIN, 2, empty columns inserted between consecutive obstacles
SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin/restart game (sampled in IDLE and OVER)
pause  in  1  level; freezes play while high in RUN
collision  in  1  hero hit detected by the top level
tipo_obs  out  4  obstacle type to the ROM, always 0..9
obstaculo  in  7  ROM pattern for tipo_obs (combinational ROM)
col_out  out  N_COLS*7  column buffer; column i at [7i+6:7i]; column 0 = hero column
step  out  1  one-cycle pulse on each scroll step
score  out  16  obstacles passed
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: state=IDLE, col_out=0, score=0, step=0, tipo_obs=0, lfsr=SEED, tick=0, gap_cnt=0, period=TICK_DIV.
- IDLE: start -> RUN; buffer, score, tick and gap_cnt cleared on the same edge. LFSR is not reseeded.
- RUN:
  - tick increments each cycle.
  - When tick==period-1: tick<=0 and step=1 for that one cycle.
  - Step cadence: first step occurs period cycles after entering RUN.
- Scroll step:
  - Buffer shifts one column toward column 0; column 0 is discarded.
  - New column enters at N_COLS-1.
  - If gap_cnt==GAP_MIN: inserted column = obstaculo, gap_cnt<=0. Otherwise inserted column = 0, gap_cnt++.
  - So the first obstacle enters on step GAP_MIN+1.
  - score++ when the discarded column 0 was nonzero; saturates at 16'hFFFF.
  - LFSR advances one shift: 8-bit Fibonacci, taps 8,6,5,4.
  - tipo_obs <= L if L<=9, else L-10, where L = next lfsr[3:0].
  - tipo_obs is therefore stable for a full period before it is sampled; no extra ROM latency is needed.
- pause high in RUN -> PAUSE. PAUSE freezes tick, buffer and LFSR. pause low -> RUN, and tick resumes from its held value.
- collision high in RUN or PAUSE -> OVER on the next edge.
  - If collision coincides with a step, collision wins: no shift and no score change.
  - OVER holds col_out and score.
- OVER: start -> RUN with buffer, score, tick, gap_cnt and period cleared (period = TICK_DIV); LFSR keeps running state.
- collision is ignored in IDLE/OVER. start is ignored in RUN/PAUSE.
- rst asserted mid-game: all registers return to reset values on that edge, regardless of the other inputs.

Optional Feature:
OBSTACLE_SPEEDUP_EN
- Defined:
  - Every time score increments to a multiple of 8, period <= max(period - TICK_DIV/8, TICK_DIV/4), with a floor of 1.
  - The new period applies from the next step.
  - period resets to TICK_DIV on rst or restart.
- Undefined: period is constant TICK_DIV; the period register is optimised away.

Decomposition:
- Shared package/include heroe_pkg: state encodings (IDLE/RUN/PAUSE/OVER), OBS_TYPES=10, OBS_W=7, SCORE_W=16.
- One natural sub-module, obstacle_lfsr: 8-bit LFSR with enable, plus mod-10 mapping to tipo_obs.
- Buffer, FSM and counters stay in obstacle_scheduler.

Test Plan:
All cases use TICK_DIV=4, N_COLS=8, GAP_MIN=2 and a bench ROM model.
- Reset: hold rst 2 cycles -> state=00, col_out=0, score=0, tipo_obs=0, step=0.
- Start and fill: obstaculo forced 7'h63, pulse start.
  - step pulses every 4 cycles.
  - Steps 1–2 insert 0; step 3 puts 7'h63 at column 7.
  - Obstacles are 3 columns apart thereafter.
- Score: continue from the start case -> the first obstacle reaches column 0 after step 10; step 11 sets score=1; step 14 sets score=2.
- Type range: 200 steps with the real ROM -> tipo_obs always <=9 and held constant between step pulses.
- Pause/collision:
  - Pause 10 cycles -> no step, col_out unchanged.
  - Then collision on a step cycle -> state=11, col_out and score frozen.
  - start -> RUN with score=0.
- OBSTACLE_SPEEDUP_EN with TICK_DIV=32: after score reaches 8 the step interval is 28 cycles; after score 48 it is the 8-cycle floor.
